// File: rtl/jzjcore_gpio_ports.sv
// Memory-mapped GPIO block: NUM_PORTS 32-bit ports, each with DATA, DIR, PENDING (W1C)
// and ENABLE registers, synchronized inputs, rising-edge latching and one interrupt line.
module jzjcore_gpio_ports #(
    parameter int          NUM_PORTS    = 8,
    parameter logic [31:0] BASE_ADDRESS = 32'hFFFFFF00,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [31:0]            address,
    input  logic [31:0]            writeData,
    input  logic [3:0]             byteEnable,
    input  logic                   writeEnable,
    input  logic                   readEnable,
    output logic                   hit,
    output logic [31:0]            readData,
    input  logic [NUM_PORTS*32-1:0] portInput,
    output logic [NUM_PORTS*32-1:0] portOutput,
    output logic [NUM_PORTS*32-1:0] portDirection,
    output logic                   interrupt
);

    localparam int W        = NUM_PORTS * 32;
    localparam int ADDR_LSB = $clog2(NUM_PORTS * 16);
    localparam int SEL_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        REG_DATA    = 2'd0,
        REG_DIR     = 2'd1,
        REG_PENDING = 2'd2,
        REG_ENABLE  = 2'd3
    } reg_e;

    logic [W-1:0]     out_q,  out_d;
    logic [W-1:0]     dir_q,  dir_d;
    logic [W-1:0]     pend_q, pend_d;
    logic [W-1:0]     en_q,   en_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [W-1:0]     sync_q [SYNC_STAGES];
    logic [W-1:0]     prev_q;

    logic [W-1:0]     sync_in;
    logic [W-1:0]     rise;
    logic [W-1:0]     data_view;
    logic [W-1:0]     w1c;
    logic [SEL_W-1:0] port_sel;
    logic [SEL_W+4:0] lane_base;
    reg_e             reg_sel;
    logic [31:0]      lane_mask;
    logic [31:0]      wr_data_m;
    logic             wr_hit;
    logic             unused_addr;

    // Byte offset bits [1:0] carry no meaning for word registers.
    assign unused_addr = ^address[1:0];

    assign hit       = (address[31:ADDR_LSB] == BASE_ADDRESS[31:ADDR_LSB]);
    assign port_sel  = SEL_W'(address[31:4] & 28'(NUM_PORTS - 1));
    assign lane_base = {port_sel, 5'b0};
    assign reg_sel   = reg_e'(address[3:2]);
    assign wr_hit    = writeEnable & hit;

    assign lane_mask = {{8{byteEnable[3]}}, {8{byteEnable[2]}},
                        {8{byteEnable[1]}}, {8{byteEnable[0]}}};
    assign wr_data_m = writeData & lane_mask;

    assign sync_in   = sync_q[SYNC_STAGES-1];
    assign rise      = sync_in & ~prev_q;
    assign data_view = (dir_q & out_q) | (~dir_q & sync_in);

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        out_d = out_q;
        dir_d = dir_q;
        en_d  = en_q;
        w1c   = '0;
        if (wr_hit) begin
            unique case (reg_sel)
                REG_DATA:    out_d[lane_base +: 32] = (out_q[lane_base +: 32] & ~lane_mask) | wr_data_m;
                REG_DIR:     dir_d[lane_base +: 32] = (dir_q[lane_base +: 32] & ~lane_mask) | wr_data_m;
                REG_PENDING: w1c[lane_base +: 32]   = wr_data_m;
                REG_ENABLE:  en_d[lane_base +: 32]  = (en_q[lane_base +: 32] & ~lane_mask) | wr_data_m;
            endcase
        end
        // A fresh edge is OR-ed in after the clear, so a simultaneous set wins.
        pend_d = (pend_q & ~w1c) | (rise & en_q);
    end

    // Read mux samples the pre-write register values.
    always_comb begin
        rdata_d = rdata_q;
        if (readEnable) begin
            if (!hit) begin
                rdata_d = '0;
            end else begin
                unique case (reg_sel)
                    REG_DATA:    rdata_d = data_view[lane_base +: 32];
                    REG_DIR:     rdata_d = dir_q[lane_base +: 32];
                    REG_PENDING: rdata_d = pend_q[lane_base +: 32];
                    REG_ENABLE:  rdata_d = en_q[lane_base +: 32];
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_q   <= '0;
            dir_q   <= '0;
            pend_q  <= '0;
            en_q    <= '0;
            rdata_q <= '0;
            prev_q  <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            out_q   <= out_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            en_q    <= en_d;
            rdata_q <= rdata_d;
            prev_q  <= sync_in;
            sync_q[0] <= portInput;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign readData      = rdata_q;
    assign portOutput    = out_q;
    assign portDirection = dir_q;
    assign interrupt     = |(pend_q & en_q);

endmodule
